reg_write_arbiter: RTL



---
 rtl/reg_write_arbiter_if.sv | 40 ++++
 rtl/reg_write_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter_if.sv
// Bundle of requester handshake signals and the register-file write port
// shared between the requesters and the write-port arbiter.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic [4:0]       start0;
  logic             dir0;
  logic [2:0]       len0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [4:0]       start1;
  logic             dir1;
  logic [2:0]       len1;
  logic [WIDTH-1:0] data1;
  logic             ack0;
  logic             ack1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic             wr_enable;
  logic [4:0]       wr_regnum;
  logic [WIDTH-1:0] wr_data;

  // Requester side: raises requests and burst fields, observes the port.
  modport master (
    output req0, start0, dir0, len0, data0,
    output req1, start1, dir1, len1, data1,
    input  ack0, ack1, done0, done1, busy,
    input  wr_enable, wr_regnum, wr_data
  );

  // Arbiter side: consumes requests, owns the register-file write port.
  modport slave (
    input  req0, start0, dir0, len0, data0,
    input  req1, start1, dir1, len1, data1,
    output ack0, ack1, done0, done1, busy,
    output wr_enable, wr_regnum, wr_data
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter and burst sequencer for the single register-file
// write port. A granted requester's burst writes len+1 consecutive
// registers (up or down, never register 0) with incrementing data.
// Every output is a flop; nothing combinational reaches the ports.
module reg_write_arbiter #(
  parameter int WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic             ptr_r;
  logic             win_r;
  logic             dir_r;
  logic [2:0]       len_r;
  logic [2:0]       beat_r;
  logic             ack0_r;
  logic             ack1_r;
  logic             done0_r;
  logic             done1_r;
  logic             busy_r;
  logic             wr_enable_r;
  logic [4:0]       wr_regnum_r;
  logic [WIDTH-1:0] wr_data_r;

  logic             win_s;
  logic [4:0]       start_s;
  logic             dir_s;
  logic [2:0]       len_s;
  logic [WIDTH-1:0] data_s;

  localparam logic [WIDTH-1:0] DATA_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Register 0 is hard-wired, so a landing on it is pushed one more step
  // in the direction of travel.
  function automatic logic [4:0] skip_zero(input logic [4:0] r, input logic up);
    if (r == 5'd0) begin
      skip_zero = up ? 5'd1 : 5'd31;
    end else begin
      skip_zero = r;
    end
  endfunction

  // Next register of a burst, wrapping modulo 32 and skipping register 0.
  function automatic logic [4:0] step_reg(input logic [4:0] r, input logic up);
    logic [4:0] n;
    n = up ? (r + 5'd1) : (r - 5'd1);
    step_reg = skip_zero(n, up);
  endfunction

  // Pick the winner among pending requests: a lone request wins, a tie
  // goes to the requester named by the round-robin pointer.
  always_comb begin
    win_s = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_s = ptr_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Route the winner's burst fields toward the latch.
  always_comb begin
    start_s = bus.start0;
    dir_s   = bus.dir0;
    len_s   = bus.len0;
    data_s  = bus.data0;
    if (win_s) begin
      start_s = bus.start1;
      dir_s   = bus.dir1;
      len_s   = bus.len1;
      data_s  = bus.data1;
    end else begin
      start_s = bus.start0;
      dir_s   = bus.dir0;
      len_s   = bus.len0;
      data_s  = bus.data0;
    end
  end

  // Grant/burst/done sequencer; all port values are computed one cycle
  // ahead so that they appear straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      win_r       <= 1'b0;
      dir_r       <= 1'b0;
      len_r       <= 3'd0;
      beat_r      <= 3'd0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      busy_r      <= 1'b0;
      wr_enable_r <= 1'b0;
      wr_regnum_r <= 5'd0;
      wr_data_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          if (bus.req0 || bus.req1) begin
            state_r     <= BURST;
            win_r       <= win_s;
            ptr_r       <= ~win_s;
            dir_r       <= dir_s;
            len_r       <= len_s;
            beat_r      <= 3'd0;
            ack0_r      <= ~win_s;
            ack1_r      <= win_s;
            busy_r      <= 1'b1;
            wr_enable_r <= 1'b1;
            wr_regnum_r <= skip_zero(start_s, dir_s);
            wr_data_r   <= data_s;
          end else begin
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            busy_r      <= 1'b0;
            wr_enable_r <= 1'b0;
            wr_regnum_r <= 5'd0;
            wr_data_r   <= {WIDTH{1'b0}};
          end
        end
        BURST: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          busy_r <= 1'b1;
          if (beat_r == len_r) begin
            state_r     <= DONE;
            wr_enable_r <= 1'b0;
            wr_regnum_r <= 5'd0;
            wr_data_r   <= {WIDTH{1'b0}};
            done0_r     <= ~win_r;
            done1_r     <= win_r;
          end else begin
            beat_r      <= beat_r + 3'd1;
            wr_enable_r <= 1'b1;
            wr_regnum_r <= step_reg(wr_regnum_r, dir_r);
            wr_data_r   <= wr_data_r + DATA_ONE;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          ack0_r      <= 1'b0;
          ack1_r      <= 1'b0;
          done0_r     <= 1'b0;
          done1_r     <= 1'b0;
          busy_r      <= 1'b0;
          wr_enable_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          ack0_r      <= 1'b0;
          ack1_r      <= 1'b0;
          done0_r     <= 1'b0;
          done1_r     <= 1'b0;
          busy_r      <= 1'b0;
          wr_enable_r <= 1'b0;
          wr_regnum_r <= 5'd0;
          wr_data_r   <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign bus.ack0      = ack0_r;
  assign bus.ack1      = ack1_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.busy      = busy_r;
  assign bus.wr_enable = wr_enable_r;
  assign bus.wr_regnum = wr_regnum_r;
  assign bus.wr_data   = wr_data_r;

endmodule
